// File: rtl/onn_pkg.sv
// Shared ONN fabric definitions: phase width, half-period threshold, phase type.
// No latency of its own.
// No backpressure of its own.
package onn_pkg;
    localparam int PW_DEF = 4;
    localparam int HALF   = 2 ** (PW_DEF - 1);

    // Also used by the phase-difference stage.
    typedef logic [PW_DEF-1:0] phase_t;
endpackage

// File: rtl/sclk_tick_gen.sv
// Oscillator tick prescaler: one tick every DIV enabled sclk cycles.
// tick is combinational from the prescaler register.
// en=0 freezes the prescaler.
module sclk_tick_gen
    import onn_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic sclk,
    input  logic re,
    input  logic en,
    output logic tick
);
    localparam int               PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] LAST  = PRE_W'(DIV - 1);

    logic [PRE_W-1:0] pre_q, pre_d;

    assign tick = en && (pre_q == LAST);

    always_comb begin
        pre_d = pre_q;
        if (tick) begin
            pre_d = '0;
        end else if (en) begin
            pre_d = pre_q + 1'b1;
        end
    end

    always_ff @(posedge sclk or negedge re) begin
        if (!re) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end
endmodule

// File: rtl/phase_osc_gen.sv
// Phase-programmable neuron oscillator: reference and lagged neuron square waves.
// Outputs are flops fed from next-state values; a new phase lands at the next period boundary.
// phase_rdy is low while one update is pending; the source must hold phase_vld.
module phase_osc_gen
    import onn_pkg::*;
#(
    parameter int PW         = PW_DEF,
    parameter int DIV        = 1,
    parameter int INIT_PHASE = 0
) (
    input  logic          sclk,
    input  logic          re,
    input  logic          en,
    input  logic [PW-1:0] phase_in,
    input  logic          phase_vld,
    output logic          phase_rdy,
    output logic [PW-1:0] phi_out,
    output logic          ref_out,
    output logic          nout,
    output logic          wrap
);
    localparam logic [PW-1:0] HALF_V   = PW'(2 ** (PW - 1));
    localparam logic [PW-1:0] INIT_V   = PW'(INIT_PHASE);
    localparam logic [PW-1:0] NEG_INIT = PW'(0) - INIT_V;
    localparam logic          NOUT_RST = (NEG_INIT < HALF_V);

    logic [PW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] phi_q, phi_d;
    logic [PW-1:0] pending_q, pending_d;
    logic          pend_q, pend_d;
    logic          ref_q, ref_d;
    logic          nout_q, nout_d;
    logic          wrap_q, wrap_d;
    logic [PW-1:0] lag_d;
    logic          tick, boundary, accept, apply;

    sclk_tick_gen #(.DIV(DIV)) u_tick (
        .sclk (sclk),
        .re   (re),
        .en   (en),
        .tick (tick)
    );

    assign boundary = tick && (cnt_q == '1);
    assign accept   = phase_vld && !pend_q;
    assign apply    = boundary && pend_q;

    // Waveforms are derived from next-state cnt/phi so they move with those registers.
    always_comb begin
        cnt_d     = tick ? cnt_q + 1'b1 : cnt_q;
        phi_d     = apply ? pending_q : phi_q;
        pending_d = accept ? phase_in : pending_q;
        pend_d    = accept | (pend_q & ~apply);
        lag_d     = cnt_d - phi_d;
        ref_d     = (cnt_d < HALF_V);
        nout_d    = (lag_d < HALF_V);
        wrap_d    = boundary;
    end

    always_ff @(posedge sclk or negedge re) begin
        if (!re) begin
            cnt_q     <= '0;
            phi_q     <= INIT_V;
            pending_q <= '0;
            pend_q    <= 1'b0;
            ref_q     <= 1'b1;
            nout_q    <= NOUT_RST;
            wrap_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            phi_q     <= phi_d;
            pending_q <= pending_d;
            pend_q    <= pend_d;
            ref_q     <= ref_d;
            nout_q    <= nout_d;
            wrap_q    <= wrap_d;
        end
    end

    assign phase_rdy = ~pend_q;
    assign phi_out   = phi_q;
    assign ref_out   = ref_q;
    assign nout      = nout_q;
    assign wrap      = wrap_q;
endmodule

// File: tb/tb_phase_osc_gen.sv
// Bench for phase_osc_gen: cycle scoreboard on the DIV=1 instance plus directed timing checks.
module tb_phase_osc_gen;
    import onn_pkg::*;

    logic   sclk = 1'b0;
    logic   re = 1'b1;
    logic   en = 1'b1;
    phase_t phase_in = '0;
    logic   phase_vld = 1'b0;
    logic   phase_rdy, ref_out, nout, wrap;
    phase_t phi_out;

    logic   en3 = 1'b1;
    phase_t phase_in3 = '0;
    logic   phase_vld3 = 1'b0;
    logic   phase_rdy3, ref_out3, nout3, wrap3;
    phase_t phi_out3;

    int n_checks = 0;
    int n_errors = 0;

    always #5 sclk = ~sclk;

    phase_osc_gen #(.PW(4), .DIV(1), .INIT_PHASE(0)) dut (
        .sclk(sclk), .re(re), .en(en), .phase_in(phase_in), .phase_vld(phase_vld),
        .phase_rdy(phase_rdy), .phi_out(phi_out), .ref_out(ref_out), .nout(nout), .wrap(wrap)
    );

    phase_osc_gen #(.PW(4), .DIV(3), .INIT_PHASE(5)) dut3 (
        .sclk(sclk), .re(re), .en(en3), .phase_in(phase_in3), .phase_vld(phase_vld3),
        .phase_rdy(phase_rdy3), .phi_out(phi_out3), .ref_out(ref_out3), .nout(nout3), .wrap(wrap3)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic   r;
        logic   n;
        logic   w;
        logic   rdy;
        phase_t phi;
    } exp_t;

    exp_t   sb[$];
    phase_t m_cnt, m_phi, m_pending, m_diff;
    logic   m_pend, m_wrap, m_old_pend, m_bnd;
    exp_t   e_push, e_pop;

    task automatic model_reset();
        m_cnt = '0; m_phi = '0; m_pending = '0; m_pend = 1'b0; m_wrap = 1'b0;
        sb.delete();
    endtask

    // Behavioural model of the DIV=1 instance: every enabled cycle is a tick.
    always @(posedge sclk) begin
        if (re) begin
            m_old_pend = m_pend;
            m_bnd = en && (m_cnt == 4'hF);
            if (m_bnd && m_old_pend) begin
                m_phi  = m_pending;
                m_pend = 1'b0;
            end
            if (phase_vld && !m_old_pend) begin
                m_pending = phase_in;
                m_pend    = 1'b1;
            end
            m_wrap = m_bnd;
            if (en) m_cnt = m_cnt + 4'd1;
            m_diff     = m_cnt - m_phi;
            e_push.r   = (m_cnt < 4'd8);
            e_push.n   = (m_diff < 4'd8);
            e_push.w   = m_wrap;
            e_push.rdy = !m_pend;
            e_push.phi = m_phi;
            sb.push_back(e_push);
        end
    end

    always @(negedge sclk) begin
        if (sb.size() != 0) begin
            e_pop = sb.pop_front();
            chk("sb_ref_out", int'(ref_out), int'(e_pop.r));
            chk("sb_nout", int'(nout), int'(e_pop.n));
            chk("sb_wrap", int'(wrap), int'(e_pop.w));
            chk("sb_phase_rdy", int'(phase_rdy), int'(e_pop.rdy));
            chk("sb_phi_out", int'(phi_out), int'(e_pop.phi));
        end
    end

    task automatic wait_wrap(input string tag);
        int n = 0;
        while (!wrap && n < 64) begin
            @(negedge sclk);
            n++;
        end
        if (!wrap) chk(tag, 0, 1);
    endtask

    task automatic wait_cnt(input phase_t c, input string tag);
        int n = 0;
        while (m_cnt != c && n < 64) begin
            @(negedge sclk);
            n++;
        end
        if (m_cnt != c) chk(tag, int'(m_cnt), int'(c));
    endtask

    // Cycles from the current (wrap-aligned) sample to the next rising edge of nout.
    task automatic measure_lag(output int lag);
        logic prev;
        lag = 0;
        do begin
            prev = nout;
            @(negedge sclk);
            lag++;
        end while (!(nout && !prev) && lag < 64);
    endtask

    initial begin
        int   n, hi, lag;
        logic prev, fz_ref, fz_nout;

        #1 re = 1'b0;
        model_reset();
        #1;
        chk("rst_ref_out", int'(ref_out), 1);
        chk("rst_nout", int'(nout), 1);
        chk("rst_wrap", int'(wrap), 0);
        chk("rst_phase_rdy", int'(phase_rdy), 1);
        chk("rst_phi_out", int'(phi_out), 0);
        chk("rst3_nout_init5", int'(nout3), 0);
        chk("rst3_phi_out", int'(phi_out3), 5);
        @(negedge sclk);
        @(negedge sclk);
        re = 1'b1;

        // Free-running period and duty.
        wait_wrap("t1_first_wrap");
        n = 0; hi = 0;
        do begin
            hi += int'(ref_out);
            @(negedge sclk);
            n++;
        end while (!wrap && n < 64);
        chk("t1_period", n, 16);
        chk("t1_ref_high", hi, 8);

        // Accept 4 at cnt=5, then hold 9 while the slot is busy.
        wait_cnt(4'd5, "t2_reach_cnt5");
        phase_in = 4'd4; phase_vld = 1'b1;
        @(negedge sclk);
        chk("t2_rdy_low", int'(phase_rdy), 0);
        chk("t2_phi_held", int'(phi_out), 0);
        phase_in = 4'd9;
        n = 0;
        while (!phase_rdy && n < 40) begin
            @(negedge sclk);
            n++;
        end
        chk("t2_phi_applied", int'(phi_out), 4);
        chk("t2_apply_at_wrap", int'(wrap), 1);
        lag = 0;
        do begin
            prev = nout;
            @(negedge sclk);
            lag++;
            if (lag == 1) begin
                phase_vld = 1'b0;
                chk("t3_captured", int'(phase_rdy), 0);
            end
        end while (!(nout && !prev) && lag < 64);
        chk("t2_lag4", lag, 4);

        @(negedge sclk);
        wait_wrap("t3_wrap");
        chk("t3_phi_applied", int'(phi_out), 9);
        measure_lag(lag);
        chk("t3_lag9", lag, 9);

        // Accept in the boundary-tick cycle: applied one full period later.
        wait_cnt(4'd15, "t4_reach_cnt15");
        phase_in = 4'd2; phase_vld = 1'b1;
        @(negedge sclk);
        phase_vld = 1'b0;
        chk("t4_phi_unchanged", int'(phi_out), 9);
        n = 0;
        while (phi_out != 4'd2 && n < 64) begin
            @(negedge sclk);
            n++;
        end
        chk("t4_apply_delay", n, 16);

        // Freeze for 10 cycles at cnt=6; accept a phase while frozen.
        wait_wrap("t5_wrap");
        n = 0; hi = 0;
        do begin
            if (hi == 0 && m_cnt == 4'd6) begin
                hi = 1;
                en = 1'b0;
                fz_ref = ref_out; fz_nout = nout;
                phase_in = 4'd6; phase_vld = 1'b1;
                repeat (10) begin
                    @(negedge sclk);
                    n++;
                    phase_vld = 1'b0;
                    chk("t5_ref_frozen", int'(ref_out), int'(fz_ref));
                    chk("t5_nout_frozen", int'(nout), int'(fz_nout));
                end
                en = 1'b1;
            end
            @(negedge sclk);
            n++;
        end while (!wrap && n < 100);
        chk("t5_stretched_period", n, 26);
        chk("t5_accept_while_disabled", int'(phi_out), 6);

        // Async reset mid-period with phi=4 and an update pending.
        phase_in = 4'd4; phase_vld = 1'b1;
        @(negedge sclk);
        phase_vld = 1'b0;
        @(negedge sclk);
        wait_wrap("t6_wrap");
        chk("t6_phi_before_rst", int'(phi_out), 4);
        phase_in = 4'd11; phase_vld = 1'b1;
        @(negedge sclk);
        phase_vld = 1'b0;
        chk("t6_pend_set", int'(phase_rdy), 0);
        repeat (3) @(negedge sclk);
        #3 re = 1'b0;
        model_reset();
        #1;
        chk("t6_rst_ref_out", int'(ref_out), 1);
        chk("t6_rst_nout", int'(nout), 1);
        chk("t6_rst_wrap", int'(wrap), 0);
        chk("t6_rst_phase_rdy", int'(phase_rdy), 1);
        chk("t6_rst_phi_out", int'(phi_out), 0);
        @(negedge sclk);
        @(negedge sclk);
        re = 1'b1;
        @(negedge sclk);
        wait_wrap("t6_wrap_after_rst");
        chk("t6_pending_dropped", int'(phi_out), 0);

        // DIV=3 instance with INIT_PHASE=5.
        n = 0;
        while (!wrap3 && n < 200) begin
            @(negedge sclk);
            n++;
        end
        if (!wrap3) chk("t5_div3_first_wrap", 0, 1);
        n = 0; hi = 0; lag = -1;
        do begin
            hi += int'(ref_out3);
            if (nout3 && lag < 0) lag = n;
            @(negedge sclk);
            n++;
        end while (!wrap3 && n < 200);
        chk("t5_div3_period", n, 48);
        chk("t5_div3_ref_high", hi, 24);
        chk("t5_div3_lag5", lag, 15);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
